// File: rtl/lsu_ctrl.sv
// Load/store unit between the core and the shared bus: one outstanding request,
// chip-select decode, REQ/GNT handshake, lane alignment, load extension, faults.
// Optional bus-timeout fault (code 3) when LSU_TIMEOUT_EN is defined.
module lsu_ctrl #(
  parameter int N_CE    = 8,
  parameter int SEL_LSB = 24,
  parameter int TIMEOUT = 255
) (
  input  logic            i_CLK,
  input  logic            i_RST_N,
  input  logic [31:0]     i_WDATA,
  input  logic [31:0]     i_ADDR,
  input  logic            i_WE,
  input  logic            i_RE,
  input  logic [1:0]      i_HB,
  input  logic            i_UNS,
  output logic [31:0]     o_RDATA,
  output logic            o_BUSY,
  output logic            o_DONE,
  output logic            o_FAULT,
  output logic [1:0]      o_FAULT_CODE,
  input  logic [31:0]     i_BUS_RDATA,
  output logic [31:0]     o_BUS_WDATA,
  output logic [31:0]     o_BUS_ADDR,
  output logic            o_BUS_WE,
  output logic [1:0]      o_BUS_HB,
  output logic [3:0]      o_BUS_BE,
  output logic [N_CE-1:0] o_BUS_CE,
  output logic            o_BUS_REQ,
  input  logic            i_BUS_GNT
);

  localparam int SW = 32 - SEL_LSB;
  localparam logic [1:0] F_MISAL = 2'd0;
  localparam logic [1:0] F_UNMAP = 2'd1;
  localparam logic [1:0] F_ILL   = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, RDWAIT, DONE} state_t;

  typedef struct packed {
    logic       ld;
    logic       uns;
    logic [1:0] lo;
  } req_t;

  state_t state;
  req_t   rq;

  logic [SW-1:0] sel;
  logic          bad_op, misal, unmap, any_fault;
  logic [1:0]    fcode;
  logic [31:0]   st_wdata;
  logic [3:0]    st_be;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld_ext;

  assign sel    = i_ADDR[31:SEL_LSB];
  assign o_BUSY = (state != IDLE);

  // Accept-time decode; fault priority is illegal > misaligned > unmapped.
  always_comb begin
    bad_op    = (i_RE & i_WE) | (i_HB == 2'b11);
    misal     = ((i_HB == 2'b01) & i_ADDR[0]) | ((i_HB == 2'b10) & (i_ADDR[1:0] != 2'b00));
    unmap     = 32'(sel) >= 32'(N_CE);
    any_fault = bad_op | misal | unmap;
    if (bad_op)     fcode = F_ILL;
    else if (misal) fcode = F_MISAL;
    else            fcode = F_UNMAP;
    case (i_HB)
      2'b00:   begin st_wdata = {4{i_WDATA[7:0]}};  st_be = 4'b0001 << i_ADDR[1:0]; end
      2'b01:   begin st_wdata = {2{i_WDATA[15:0]}}; st_be = i_ADDR[1] ? 4'b1100 : 4'b0011; end
      default: begin st_wdata = i_WDATA;            st_be = 4'b1111; end
    endcase
  end

  // Load lane extraction from the data returned in RDWAIT.
  always_comb begin
    ld_b = i_BUS_RDATA[{rq.lo, 3'b000} +: 8];
    ld_h = rq.lo[1] ? i_BUS_RDATA[31:16] : i_BUS_RDATA[15:0];
    case (o_BUS_HB)
      2'b00:   ld_ext = rq.uns ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'b01:   ld_ext = rq.uns ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld_ext = i_BUS_RDATA;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int         TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [1:0] F_TMO = 2'd3;
  logic [TW-1:0] to_cnt;
`endif

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state        <= IDLE;
      rq           <= '0;
      o_RDATA      <= '0;
      o_DONE       <= 1'b0;
      o_FAULT      <= 1'b0;
      o_FAULT_CODE <= '0;
      o_BUS_WDATA  <= '0;
      o_BUS_ADDR   <= '0;
      o_BUS_WE     <= 1'b0;
      o_BUS_HB     <= '0;
      o_BUS_BE     <= '0;
      o_BUS_CE     <= '0;
      o_BUS_REQ    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      o_DONE <= 1'b0;
      case (state)
        IDLE: if (i_RE | i_WE) begin
          rq <= '{ld: i_RE, uns: i_UNS, lo: i_ADDR[1:0]};
          if (any_fault) begin
            o_DONE       <= 1'b1;
            o_FAULT      <= 1'b1;
            o_FAULT_CODE <= fcode;
            state        <= DONE;
          end else begin
            o_BUS_REQ   <= 1'b1;
            o_BUS_CE    <= N_CE'(1) << sel;
            o_BUS_WE    <= i_WE;
            o_BUS_HB    <= i_HB;
            o_BUS_BE    <= st_be;
            o_BUS_WDATA <= st_wdata;
            o_BUS_ADDR  <= {{SW{1'b0}}, i_ADDR[SEL_LSB-1:0]};
`ifdef LSU_TIMEOUT_EN
            to_cnt      <= '0;
`endif
            state       <= REQ;
          end
        end
        REQ: begin
          if (i_BUS_GNT) begin
            o_BUS_REQ <= 1'b0;
            o_BUS_CE  <= '0;
            o_BUS_WE  <= 1'b0;
            if (rq.ld) begin
              state <= RDWAIT;
            end else begin
              o_DONE <= 1'b1;
              state  <= DONE;
            end
          end
`ifdef LSU_TIMEOUT_EN
          // Grant wins over expiry because it is tested first.
          else if (to_cnt == TW'(TIMEOUT - 1)) begin
            o_BUS_REQ    <= 1'b0;
            o_BUS_CE     <= '0;
            o_BUS_WE     <= 1'b0;
            o_DONE       <= 1'b1;
            o_FAULT      <= 1'b1;
            o_FAULT_CODE <= F_TMO;
            state        <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RDWAIT: begin
          o_RDATA <= ld_ext;
          o_DONE  <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          o_FAULT      <= 1'b0;
          o_FAULT_CODE <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl (default build): expected completions are queued
// when a request is driven and checked when o_DONE appears.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wdata, addr, bus_rdata;
  logic        we, re, uns, gnt;
  logic [1:0]  hb;
  logic [31:0] rdata, bus_wdata, bus_addr;
  logic        busy, done, fault, bus_we, bus_req;
  logic [1:0]  fault_code, bus_hb;
  logic [3:0]  bus_be;
  logic [7:0]  bus_ce;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  code;
  } exp_t;

  exp_t sb[$];
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.N_CE(8), .SEL_LSB(24), .TIMEOUT(255)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_WDATA(wdata), .i_ADDR(addr), .i_WE(we), .i_RE(re),
    .i_HB(hb), .i_UNS(uns), .o_RDATA(rdata), .o_BUSY(busy), .o_DONE(done), .o_FAULT(fault),
    .o_FAULT_CODE(fault_code), .i_BUS_RDATA(bus_rdata), .o_BUS_WDATA(bus_wdata),
    .o_BUS_ADDR(bus_addr), .o_BUS_WE(bus_we), .o_BUS_HB(bus_hb), .o_BUS_BE(bus_be),
    .o_BUS_CE(bus_ce), .o_BUS_REQ(bus_req), .i_BUS_GNT(gnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Completion monitor: every o_DONE pulse retires one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", rdata, e.rdata);
        chk("fault", {31'b0, fault}, {31'b0, e.fault});
        chk("fault_code", {30'b0, fault_code}, {30'b0, e.code});
      end
    end
  end

  // One request with a bus model that grants after gdly REQ cycles and returns
  // bus_word the cycle after the grant. Bus outputs are checked on every REQ cycle.
  task automatic run_op(input string nm, input logic w, input logic r, input logic [1:0] h,
                        input logic u, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] bus_word, input int gdly,
                        input logic [7:0] e_ce, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic [31:0] e_addr,
                        input int e_reqc, input int e_done,
                        input logic [31:0] e_rd, input logic e_f, input logic [1:0] e_code);
    int  reqc = 0;
    int  done_cyc = -1;
    logic gnt_prev = 1'b0;
    exp_t e;
    @(posedge clk); #1;
    we = w; re = r; hb = h; uns = u; addr = a; wdata = wd;
    e.rdata = e_rd; e.fault = e_f; e.code = e_code;
    sb.push_back(e);
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; wdata = 32'h5555_5555; addr = 32'hFFFF_FFFF;
    for (int cyc = 1; cyc < 40; cyc++) begin
      bus_rdata = gnt_prev ? bus_word : 32'h0BAD_0BAD;
      gnt_prev  = 1'b0;
      gnt       = 1'b0;
      if (bus_req) begin
        reqc++;
        chk({nm, "_ce"}, {24'b0, bus_ce}, {24'b0, e_ce});
        chk({nm, "_be"}, {28'b0, bus_be}, {28'b0, e_be});
        chk({nm, "_wd"}, bus_wdata, e_wd);
        chk({nm, "_addr"}, bus_addr, e_addr);
        chk({nm, "_we"}, {31'b0, bus_we}, {31'b0, w});
        if (reqc > gdly) begin gnt = 1'b1; gnt_prev = 1'b1; end
      end
      if (done) begin done_cyc = cyc; break; end
      @(posedge clk); #1;
    end
    gnt = 1'b0;
    chk({nm, "_reqcycles"}, reqc, e_reqc);
    chk({nm, "_donecycle"}, done_cyc, e_done);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; we = 0; re = 0; hb = 0; uns = 0; addr = 0; wdata = 0;
    bus_rdata = 0; gnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, bus_req}, 32'd0);
    chk("rst_ce", {24'b0, bus_ce}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_be", {28'b0, bus_be}, 32'd0);
    rst_n = 1'b1;

    //      name   we re hb    u  addr          wdata         bus           g  ce     be       wd            addr          rq dn rdata         f  code
    run_op("sw",   1, 0, 2'b10, 0, 32'h0200_0000, 32'hDEAD_BEEF, 32'h0,        2, 8'h04, 4'b1111, 32'hDEAD_BEEF, 32'h0,        3, 4, 32'h0,        0, 0);
    run_op("lb",   0, 1, 2'b00, 0, 32'h0100_0003, 32'h0,         32'h80FF_FFFF, 0, 8'h02, 4'b1000, 32'h0,        32'h3,        1, 3, 32'hFFFF_FF80, 0, 0);
    run_op("lbu",  0, 1, 2'b00, 1, 32'h0100_0003, 32'h0,         32'h80FF_FFFF, 1, 8'h02, 4'b1000, 32'h0,        32'h3,        2, 4, 32'h0000_0080, 0, 0);
    run_op("sh",   1, 0, 2'b01, 0, 32'h0000_0002, 32'h0000_1234, 32'h0,        0, 8'h01, 4'b1100, 32'h1234_1234, 32'h2,        1, 2, 32'h0000_0080, 0, 0);
    run_op("lh",   0, 1, 2'b01, 0, 32'h0000_0002, 32'h0,         32'h8001_5A5A, 0, 8'h01, 4'b1100, 32'h0,        32'h2,        1, 3, 32'hFFFF_8001, 0, 0);
    run_op("lhu",  0, 1, 2'b01, 1, 32'h0000_0000, 32'h0,         32'h1234_F00D, 0, 8'h01, 4'b0011, 32'h0,        32'h0,        1, 3, 32'h0000_F00D, 0, 0);
    run_op("sb",   1, 0, 2'b00, 0, 32'h0500_0001, 32'hFFFF_FFA5, 32'h0,        1, 8'h20, 4'b0010, 32'hA5A5_A5A5, 32'h1,        2, 3, 32'h0000_F00D, 0, 0);
    run_op("lb1",  0, 1, 2'b00, 0, 32'h0500_0001, 32'h0,         32'h0000_7F00, 0, 8'h20, 4'b0010, 32'h0,        32'h1,        1, 3, 32'h0000_007F, 0, 0);
    run_op("lw7",  0, 1, 2'b10, 0, 32'h0700_0010, 32'h0,         32'hCAFE_BABE, 0, 8'h80, 4'b1111, 32'h0,        32'h10,       1, 3, 32'hCAFE_BABE, 0, 0);
    run_op("misal",0, 1, 2'b10, 0, 32'h0000_0002, 32'h0,         32'h0,        0, 8'h00, 4'b0000, 32'h0,        32'h0,        0, 1, 32'hCAFE_BABE, 1, 0);
    run_op("hmis", 1, 0, 2'b01, 0, 32'h0000_0003, 32'h0,         32'h0,        0, 8'h00, 4'b0000, 32'h0,        32'h0,        0, 1, 32'hCAFE_BABE, 1, 0);
    run_op("unm9", 0, 1, 2'b10, 0, 32'h0900_0000, 32'h0,         32'h0,        0, 8'h00, 4'b0000, 32'h0,        32'h0,        0, 1, 32'hCAFE_BABE, 1, 1);
    run_op("unm8", 1, 0, 2'b00, 0, 32'h0800_0000, 32'h0,         32'h0,        0, 8'h00, 4'b0000, 32'h0,        32'h0,        0, 1, 32'hCAFE_BABE, 1, 1);
    run_op("hb11", 0, 1, 2'b11, 0, 32'h0000_0000, 32'h0,         32'h0,        0, 8'h00, 4'b0000, 32'h0,        32'h0,        0, 1, 32'hCAFE_BABE, 1, 2);
    run_op("rewe", 1, 1, 2'b10, 0, 32'h0900_0001, 32'h0,         32'h0,        0, 8'h00, 4'b0000, 32'h0,        32'h0,        0, 1, 32'hCAFE_BABE, 1, 2);

    // Reset while a store waits in REQ; the transaction is lost.
    @(posedge clk); #1;
    we = 1'b1; hb = 2'b10; addr = 32'h0200_0004; wdata = 32'h1111_2222;
    @(posedge clk); #1;
    we = 1'b0;
    chk("pre_rst_req", {31'b0, bus_req}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_req", {31'b0, bus_req}, 32'd0);
    chk("async_ce", {24'b0, bus_ce}, 32'd0);
    chk("async_done", {31'b0, done}, 32'd0);
    chk("async_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("lw_post", 0, 1, 2'b10, 0, 32'h0300_0004, 32'h0, 32'h1122_3344, 1, 8'h08, 4'b1111, 32'h0, 32'h4, 2, 4, 32'h1122_3344, 0, 0);

    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Registered, parametrised load/store unit between the PYGMY-V32I core and the shared system bus. It latches one core memory request and decodes the chip select from the upper address field. It runs a REQ/GNT handshake and aligns byte/halfword/word data onto bus byte lanes, then sign- or zero-extends returned load data. It also reports misaligned, illegal and unmapped accesses as faults, and can optionally report bus timeouts.

## Interface
- N_CE, 8: number of bus chip enables / mapped regions
- SEL_LSB, 24: chip-select field is i_ADDR[31:SEL_LSB]; offset is i_ADDR[SEL_LSB-1:0]
- TIMEOUT, 255: max cycles in REQ without grant (used only with LSU_TIMEOUT_EN)

- i_CLK  in  1  clock, rising edge
- i_RST_N  in  1  asynchronous, active-low reset
- i_WDATA  in  32  store data (right-aligned)
- i_ADDR  in  32  byte address
- i_WE  in  1  store request, sampled in IDLE
- i_RE  in  1  load request, sampled in IDLE
- i_HB  in  2  size: 00 byte, 01 half, 10 word, 11 illegal
- i_UNS  in  1  load zero-extend (1) / sign-extend (0)
- o_RDATA  out  32  extended load data, held until next successful load
- o_BUSY  out  1  state != IDLE
- o_DONE  out  1  one-cycle completion pulse (success or fault)
- o_FAULT  out  1  valid with o_DONE
- o_FAULT_CODE  out  2  0 misaligned, 1 unmapped, 2 illegal op/size, 3 timeout
- i_BUS_RDATA  in  32  bus read data, valid the cycle after GNT
- o_BUS_WDATA  out  32  lane-replicated store data
- o_BUS_ADDR  out  32  {zeros, offset}
- o_BUS_WE  out  1  write strobe
- o_BUS_HB  out  2  registered size
- o_BUS_BE  out  4  byte enables
- o_BUS_CE  out  N_CE  one-hot chip enable
- o_BUS_REQ  out  1  bus request
- i_BUS_GNT  in  1  bus grant

## Operation
- States: IDLE, REQ, RDWAIT, DONE. Reset: state IDLE, every output 0, o_RDATA 0.
- IDLE: if i_RE|i_WE, latch addr/data/size/op/i_UNS, then check in priority order: i_RE&i_WE or i_HB=11 -> code 2; half with addr[0]=1 or word with addr[1:0]!=0 -> code 0; select field >= N_CE -> code 1. Any fault -> DONE with fault, no bus activity. Otherwise -> REQ.
- REQ: o_BUS_REQ=1; ADDR/CE/WE/HB/BE/WDATA driven from registers, stable until leaving REQ. GNT high at edge: store -> DONE; load -> RDWAIT.
- RDWAIT: capture i_BUS_RDATA, extract lane (byte at addr[1:0], half at addr[1]), extend per i_UNS into o_RDATA -> DONE.
- DONE: o_DONE=1 for one cycle, o_FAULT/o_FAULT_CODE valid -> IDLE. Faults and stores leave o_RDATA unchanged.
- Store lanes: byte {4{b}}, BE=0001<<addr[1:0]; half {2{h}}, BE=0011<<(2*addr[1]); word BE=1111.
- o_BUS_CE = 1<<select when REQ, else 0. Requests while o_BUSY are ignored; the core stalls on o_BUSY.

## Timing
- Store: accept at edge 0, REQ from cycle 1; GNT sampled at edge 1 gives o_DONE in cycle 2. Minimum 3 cycles.
- Load: GNT at edge 1, RDWAIT in cycle 2, o_RDATA updated and o_DONE in cycle 3. Minimum 4 cycles.
- Fault detected at accept: o_DONE+o_FAULT in cycle 1.
- A new request is accepted in the cycle after DONE (IDLE).
- Reset asserted mid-transaction: o_BUS_REQ, o_BUS_CE and o_DONE drop immediately and asynchronously; the transaction is lost.

## Configuration
- LSU_TIMEOUT_EN defined: counter cleared on REQ entry, incremented per REQ cycle without GNT. On reaching TIMEOUT, drop REQ -> DONE with code 3. GNT in the same cycle as expiry: grant wins.
- Undefined: REQ waits indefinitely, no counter logic, TIMEOUT ignored, code 3 never produced.

## Test plan
- SW 0xDEADBEEF to 0x0200_0000, GNT after 2 cycles -> REQ held 3 cycles; CE=0x04; ADDR=0x0; BE=1111; o_DONE with no fault.
- LB at 0x0100_0003, i_UNS=0, bus returns 0x80FF_FFFF -> o_RDATA=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- SH 0x1234 to 0x0000_0002 -> WDATA=0x1234_1234, BE=1100. LH of 0x8001xxxx at offset 2 -> 0xFFFF_8001.
- LW at 0x0000_0002 -> o_DONE+fault code 0 in cycle 1, o_BUS_REQ never asserted. Address 0x0900_0000 -> code 1. i_HB=11 -> code 2.
- With LSU_TIMEOUT_EN and TIMEOUT=4, GNT never asserted -> REQ drops after 4 cycles, fault code 3. GNT on 4th cycle -> normal completion.
- i_RST_N pulled low while in REQ -> o_BUS_REQ=0 the same cycle. After release, a new LW completes normally.
